// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full, sticky error flags and flush.
// Define SHOWAHEAD_EN for first-word-fall-through output; the default is a registered q with 1-cycle latency.
module param_sync_fifo #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 16,
  parameter int ALMOST_FULL_TH = DEPTH-2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic [DATA_WIDTH-1:0]       data,
  input  logic                        wrreq,
  input  logic                        rdreq,
  output logic [DATA_WIDTH-1:0]       q,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic [$clog2(DEPTH):0]      usedw,
  output logic                        overflow,
  output logic                        underflow
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           usedw_nxt;
  logic                  wr_ok, rd_ok;

  // Acceptance uses registered flags, so a same-cycle read never frees room for a write.
  assign wr_ok = wrreq && !full  && !clear;
  assign rd_ok = rdreq && !empty && !clear;

  always_comb begin
    usedw_nxt = usedw;
    if (clear)                usedw_nxt = '0;
    else if (wr_ok && !rd_ok) usedw_nxt = usedw + 1'b1;
    else if (rd_ok && !wr_ok) usedw_nxt = usedw - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      usedw       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      usedw       <= usedw_nxt;
      empty       <= (usedw_nxt == '0);
      full        <= (usedw_nxt == (AW+1)'(DEPTH));
      almost_full <= (usedw_nxt >= (AW+1)'(ALMOST_FULL_TH));
      if (clear) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        // DEPTH is a power of two, so pointer wrap is natural overflow.
        if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
        if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        if (wrreq && full)  overflow  <= 1'b1;
        if (rdreq && empty) underflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset: contents are meaningless until written.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= data;
  end

`ifdef SHOWAHEAD_EN
  // Head word is presented combinationally; forced to zero while empty to avoid X on q.
  assign q = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      q <= '0;
    else if (rd_ok) q <= mem[rd_ptr];
  end
`endif

endmodule
